// File: rtl/logic_arb_pkg.sv
// Shared opcode and state encodings for the two-requester logic-unit arbiter.
package logic_arb_pkg;

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_PASSA = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise unit shared by both requesters.
// XOR support is present only when LOGIC_ARB_XOR_EN is defined; otherwise op 10 flags err.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
`ifdef LOGIC_ARB_XOR_EN
      OP_XOR:   result = a ^ b;
`else
      OP_XOR:   err    = 1'b1;
`endif
      OP_PASSA: result = a;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters, with a
// single registered response slot. Optional macro: LOGIC_ARB_XOR_EN.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [1:0]       req0Op,
  input  logic [WIDTH-1:0] req0A,
  input  logic [WIDTH-1:0] req0B,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [1:0]       req1Op,
  input  logic [WIDTH-1:0] req1A,
  input  logic [WIDTH-1:0] req1B,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic             rspId,
  output logic             rspErr
);

  logic [0:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant, slot_free, hs;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel, lu_result;
  logic             lu_err;

  // On a tie the requester that did not win last time goes next.
  assign grant     = (req0Valid & req1Valid) ? ~last_grant_q : req1Valid;
  assign slot_free = (state_q == ST_IDLE) | rspReady;
  assign hs        = resetN & slot_free & (req0Valid | req1Valid);

  assign req0Ready = hs & ~grant;
  assign req1Ready = hs & grant;

  assign op_sel = grant ? req1Op : req0Op;
  assign a_sel  = grant ? req1A  : req0A;
  assign b_sel  = grant ? req1B  : req0B;

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op     (op_sel),
    .a      (a_sel),
    .b      (b_sel),
    .result (lu_result),
    .err    (lu_err)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    if (hs) begin
      state_d      = ST_HOLD;
      last_grant_d = grant;
      rsp_data_d   = lu_result;
      rsp_id_d     = grant;
      rsp_err_d    = lu_err;
    end else if (state_q == ST_HOLD && rspReady) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rspValid = (state_q == ST_HOLD);
  assign rspData  = rsp_data_q;
  assign rspId    = rsp_id_q;
  assign rspErr   = rsp_err_q;

endmodule
